// File: rtl/conv_pkg.sv
// Shared FSM state encoding and datapath widths for the convolution scheduler.
package conv_pkg;

  localparam int PIXEL_W  = 8;
  localparam int RESULT_W = 22;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant while enabled, pointer moves on each grant.
// Zero latency; the requester not served last wins a tie, requester 0 after reset.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       arb_en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio_one;  // 1: requester 1 wins a simultaneous request

  always_comb begin
    gnt = 2'b00;
    if (arb_en) begin
      if (prio_one) gnt = req[1] ? 2'b10 : {1'b0, req[0]};
      else          gnt = req[0] ? 2'b01 : {req[1], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        prio_one <= 1'b0;
    else if (gnt[0]) prio_one <= 1'b1;
    else if (gnt[1]) prio_one <= 1'b0;
  end

endmodule

// File: rtl/conv_scheduler.sv
// Grants the convolution engine to one of two requesters per frame, streams its pixels and qualifies results.
// Pixels pass through combinationally; results are qualified by a 5-cycle mask and have no backpressure.
module conv_scheduler
  import conv_pkg::*;
#(
  parameter  int IMG_SIZE = 32,
  localparam int N_OUT    = (IMG_SIZE - 2) * (IMG_SIZE - 2)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req,
  output logic [1:0]                 grant,
  input  logic [1:0]                 src_valid,
  input  logic [PIXEL_W-1:0]         src_pixel0,
  input  logic [PIXEL_W-1:0]         src_pixel1,
  output logic [1:0]                 src_ready,
  output logic                       eng_start,
  output logic [PIXEL_W-1:0]         eng_pixel,
  output logic                       eng_pixel_valid,
  input  logic signed [RESULT_W-1:0] eng_result,
  input  logic                       eng_result_valid,
  input  logic                       eng_done,
  output logic                       out_valid,
  output logic signed [RESULT_W-1:0] out_data,
  output logic                       out_id,
  output logic                       out_last,
  output logic                       busy
);

  localparam int XW = (IMG_SIZE > 2) ? $clog2(IMG_SIZE) : 1;
  localparam int CW = $clog2(N_OUT + 1);
  localparam logic [XW-1:0] X_MAX    = XW'(IMG_SIZE - 1);
  localparam logic [XW-1:0] X_WIN    = XW'(2);
  localparam logic [CW-1:0] CNT_FULL = CW'(N_OUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(N_OUT - 1);

  state_t          state, state_nxt;
  logic [XW-1:0]   px_x, px_y;
  logic [CW-1:0]   res_cnt;
  logic [4:0]      mask;
  logic            mask_in;
  logic            arm;
  logic            done_seen;
  logic            arb_en;
  logic [1:0]      arb_gnt;
  logic            last_px;

  assign arb_en  = (state == S_IDLE) && arm;
  assign last_px = (px_x == X_MAX) && (px_y == X_MAX);
  // Pre-increment position: only pixels completing a full 3x3 window yield a result.
  assign mask_in = eng_pixel_valid && (px_x >= X_WIN) && (px_y >= X_WIN);

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .arb_en (arb_en),
    .req    (req),
    .gnt    (arb_gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (arb_gnt != 2'b00) state_nxt = S_START;
      S_START:  state_nxt = S_STREAM;
      S_STREAM: if (eng_pixel_valid && last_px) state_nxt = S_DRAIN;
      S_DRAIN:  if (res_cnt == CNT_FULL) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    eng_start       = (state == S_START);
    busy            = (state != S_IDLE);
    src_ready       = (state == S_STREAM) ? grant : 2'b00;
    eng_pixel_valid = (state == S_STREAM) && src_valid[out_id];
    eng_pixel       = (state == S_STREAM) ? (out_id ? src_pixel1 : src_pixel0) : '0;
    out_valid       = eng_result_valid && mask[4] && busy;
    out_data        = eng_result;
    out_last        = out_valid && (res_cnt == CNT_LAST);
  end

  // Holds off the first grant until the second edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) arm <= 1'b0;
    else      arm <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant  <= 2'b00;
      out_id <= 1'b0;
    end else if (arb_gnt != 2'b00) begin
      grant  <= arb_gnt;
      out_id <= arb_gnt[1];
    end else if (state == S_DONE) begin
      grant  <= 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      px_x <= '0;
      px_y <= '0;
    end else if (state == S_START) begin
      px_x <= '0;
      px_y <= '0;
    end else if (eng_pixel_valid) begin
      if (px_x == X_MAX) begin
        px_x <= '0;
        px_y <= px_y + XW'(1);
      end else begin
        px_x <= px_x + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_cnt   <= '0;
      mask      <= '0;
      done_seen <= 1'b0;
    end else begin
      mask <= {mask[3:0], mask_in};
      if (state == S_START)  res_cnt <= '0;
      else if (out_valid)    res_cnt <= res_cnt + CW'(1);
      if (state == S_START)  done_seen <= 1'b0;
      else if (eng_done)     done_seen <= 1'b1;
    end
  end

  // End-of-frame from the engine is informational; it must never precede a qualified result.
  always_ff @(posedge clk) begin
    if (rst && out_valid) assert (!done_seen);
  end

endmodule

// File: tb/tb_conv_scheduler.sv
// Directed bench for conv_scheduler at IMG_SIZE=4 with a 3x3 box-sum engine model (5-cycle latency).
module tb_conv_scheduler;
  import conv_pkg::*;

  localparam int IMG = 4;
  localparam int EXP_SUM [4] = '{45, 54, 81, 90};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       rst;
  logic [1:0]                 req, grant, src_valid, src_ready;
  logic [PIXEL_W-1:0]         src_pixel0, src_pixel1, eng_pixel;
  logic                       eng_start, eng_pixel_valid, eng_result_valid, eng_done;
  logic signed [RESULT_W-1:0] eng_result, out_data;
  logic                       out_valid, out_id, out_last, busy;

  conv_scheduler #(.IMG_SIZE(IMG)) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .grant            (grant),
    .src_valid        (src_valid),
    .src_pixel0       (src_pixel0),
    .src_pixel1       (src_pixel1),
    .src_ready        (src_ready),
    .eng_start        (eng_start),
    .eng_pixel        (eng_pixel),
    .eng_pixel_valid  (eng_pixel_valid),
    .eng_result       (eng_result),
    .eng_result_valid (eng_result_valid),
    .eng_done         (eng_done),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_id           (out_id),
    .out_last         (out_last),
    .busy             (busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit noise    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Engine model: box sum over the 3x3 window ending at each full-window pixel,
  // result 5 cycles after the pixel; junk (-1) strobed on every other cycle.
  logic [7:0]                 img [16];
  int                         in_cnt, real_out;
  logic [4:0]                 pv;
  logic signed [RESULT_W-1:0] pd [5];

  function automatic logic signed [RESULT_W-1:0] win_sum(input int idx, input logic [7:0] cur);
    int x, y, s, k;
    x = idx % IMG;
    y = idx / IMG;
    s = 0;
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++) begin
        k = (y - 2 + dy) * IMG + (x - 2 + dx);
        if (k == idx)             s += int'(cur);
        else if (k >= 0 && k < 16) s += int'(img[k]);
      end
    return RESULT_W'(s);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_cnt   <= 0;
      real_out <= 0;
      pv       <= '0;
      eng_done <= 1'b0;
      for (int j = 0; j < 5; j++) pd[j] <= '0;
    end else begin
      if (eng_start) in_cnt <= 0;
      else if (eng_pixel_valid && in_cnt < 16) begin
        img[in_cnt] <= eng_pixel;
        in_cnt      <= in_cnt + 1;
      end
      pv    <= {pv[3:0], eng_pixel_valid && (in_cnt % IMG) >= 2 && (in_cnt / IMG) >= 2};
      pd[0] <= win_sum(in_cnt, eng_pixel);
      for (int j = 1; j < 5; j++) pd[j] <= pd[j-1];
      eng_done <= pv[4] && real_out == 3;
      if (pv[4]) real_out <= (real_out == 3) ? 0 : real_out + 1;
    end
  end

  assign eng_result_valid = 1'b1;
  assign eng_result       = pv[4] ? pd[4] : -22'sd1;

  int q_data[$];
  int q_id[$];
  int q_last[$];

  always @(negedge clk) begin
    if (rst && out_valid) begin
      q_data.push_back(int'(out_data));
      q_id.push_back(int'(out_id));
      q_last.push_back(int'(out_last));
    end
  end

  task automatic reset_with(input logic [1:0] r);
    rst        = 1'b0;
    req        = r;
    src_valid  = 2'b00;
    src_pixel0 = '0;
    src_pixel1 = '0;
    repeat (2) @(posedge clk);
    #1;
    q_data.delete(); q_id.delete(); q_last.delete();
    rst = 1'b1;
  endtask

  task automatic wait_start(input string tag, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!eng_start && cyc < 60);
    check({tag, "_start"}, eng_start, 1);
  endtask

  task automatic send_frame(input int who, input int base, input int first, input int last,
                            input int gap_at, input int gap_len);
    bit ok;
    @(posedge clk); #1;
    for (int i = first; i <= last; i++) begin
      if (i == gap_at) begin
        src_valid[who] = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
      src_valid[who] = 1'b1;
      if (who == 0) src_pixel0 = 8'(base + i);
      else          src_pixel1 = 8'(base + i);
      if (noise && who == 0) begin
        src_valid[1] = (i % 2 == 1);
        src_pixel1   = 8'hEE;
      end
      ok = 1'b0;
      for (int t = 0; t < 40 && !ok; t++) begin
        @(negedge clk);
        ok = src_ready[who];
        if (ok) begin
          check("pix", eng_pixel, 8'(base + i));
          check("rdy_other", src_ready[1-who], 0);
        end else if (t < 39) begin
          @(posedge clk); #1;
        end
      end
      if (!ok) begin
        check("accept_timeout", 0, 1);
        src_valid = 2'b00;
        return;
      end
      @(posedge clk); #1;
    end
    src_valid = 2'b00;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    bit gz;
    t  = 0;
    gz = 1'b0;
    do begin
      @(negedge clk);
      t++;
      if (busy && grant == 2'b00) gz = 1'b1;
    end while (busy && t < 100);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_gnt_held"}, gz, 0);
    check({tag, "_gnt_rel"}, grant, 0);
  endtask

  task automatic check_results(input string tag, input int id, input int base);
    check({tag, "_nres"}, q_data.size(), 4);
    for (int k = 0; k < 4 && k < q_data.size(); k++) begin
      check({tag, "_dat"}, q_data[k], EXP_SUM[k] + 9 * base);
      check({tag, "_id"}, q_id[k], id);
      check({tag, "_last"}, q_last[k], (k == 3) ? 1 : 0);
    end
    q_data.delete(); q_id.delete(); q_last.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;

    // Single requester, gapless frame; reset values checked with req already high.
    rst = 1'b0; req = 2'b01; src_valid = 2'b00; src_pixel0 = '0; src_pixel1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_rdy", src_ready, 0);
    check("rst_start", eng_start, 0);
    check("rst_pv", eng_pixel_valid, 0);
    check("rst_ov", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    wait_start("t1", cyc);
    check("t1_start_lat", cyc, 3);
    check("t1_grant", grant, 2'b01);
    check("t1_busy", busy, 1);
    @(posedge clk); #1;
    check("t1_start_pulse", eng_start, 0);
    req = 2'b00;
    send_frame(0, 0, 0, 15, -1, 0);
    wait_idle("t1");
    check_results("t1", 0, 0);

    // Both request from reset: requester 0 first, then requester 1.
    reset_with(2'b11);
    wait_start("t2a", cyc);
    check("t2a_grant", grant, 2'b01);
    send_frame(0, 0, 0, 15, -1, 0);
    wait_start("t2b", cyc);
    check("t2b_grant", grant, 2'b10);
    req = 2'b00;
    check_results("t2a", 0, 0);
    send_frame(1, 10, 0, 15, -1, 0);
    wait_idle("t2b");
    check_results("t2b", 1, 10);

    // Three-cycle source bubble mid-frame while the engine strobes junk.
    reset_with(2'b01);
    wait_start("t3", cyc);
    req = 2'b00;
    send_frame(0, 20, 0, 15, 9, 3);
    wait_idle("t3");
    check_results("t3", 0, 20);

    // Asynchronous reset while pixel 7 is presented, then a requester-1 frame.
    reset_with(2'b01);
    wait_start("t4", cyc);
    req = 2'b00;
    send_frame(0, 0, 0, 6, -1, 0);
    src_valid[0] = 1'b1;
    src_pixel0   = 8'd7;
    #2;
    check("t4_pv_pre", eng_pixel_valid, 1);
    rst = 1'b0;
    #1;
    check("t4_grant", grant, 0);
    check("t4_rdy", src_ready, 0);
    check("t4_busy", busy, 0);
    check("t4_start", eng_start, 0);
    check("t4_pv", eng_pixel_valid, 0);
    check("t4_ov", out_valid, 0);
    check("t4_last", out_last, 0);
    src_valid = 2'b00;
    req = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    q_data.delete(); q_id.delete(); q_last.delete();
    rst = 1'b1;
    wait_start("t4b", cyc);
    check("t4b_grant", grant, 2'b10);
    req = 2'b00;
    send_frame(1, 5, 0, 15, -1, 0);
    wait_idle("t4b");
    check_results("t4b", 1, 5);

    // Request withdrawn mid-stream: frame still completes under the same grant.
    reset_with(2'b01);
    wait_start("t5", cyc);
    send_frame(0, 40, 0, 4, -1, 0);
    req = 2'b00;
    #1;
    check("t5_gnt_mid", grant, 2'b01);
    check("t5_busy_mid", busy, 1);
    send_frame(0, 40, 5, 15, -1, 0);
    wait_idle("t5");
    check_results("t5", 0, 40);

    // Non-owner toggling valid with foreign data must not reach the engine.
    reset_with(2'b01);
    noise = 1'b1;
    wait_start("t6", cyc);
    req = 2'b00;
    send_frame(0, 30, 0, 15, -1, 0);
    noise = 1'b0;
    wait_idle("t6");
    check_results("t6", 0, 30);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
